// File: rtl/stream_arbiter_qos_rr.sv
// Packet stream arbiter: highest QoS wins, round-robin breaks ties, aging rescues
// starved streams. Grant locks until `last`; a 2-entry skid buffer feeds the output.
module stream_arbiter_qos_rr #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS__WIDTH = 4,
    parameter int STREAM_COUNT = 4,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
    parameter int AGE_LIMIT    = 15,
    parameter int AGE_WIDTH    = $clog2(AGE_LIMIT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_in  [STREAM_COUNT],
    input  logic [T_QOS__WIDTH-1:0] s_qos_in   [STREAM_COUNT],
    input  logic [STREAM_COUNT-1:0] s_last_in,
    input  logic [STREAM_COUNT-1:0] s_valid_in,
    output logic [STREAM_COUNT-1:0] s_ready_out,
    output logic [T_DATA_WIDTH-1:0] m_data_out,
    output logic [T_QOS__WIDTH-1:0] m_qos_out,
    output logic [T_ID___WIDTH-1:0] m_id_out,
    output logic                    m_last_out,
    output logic                    m_valid_out,
    input  logic                    m_ready_in
);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]              state;
    logic [T_ID___WIDTH-1:0] grant;
    logic [T_ID___WIDTH-1:0] rr_ptr;
    logic [T_QOS__WIDTH-1:0] pkt_qos;
    logic [AGE_WIDTH-1:0]    age [STREAM_COUNT];

    logic                    any_valid;
    logic [STREAM_COUNT-1:0] urgent;
    logic [STREAM_COUNT-1:0] cand;
    logic [T_QOS__WIDTH-1:0] max_qos;
    logic [T_ID___WIDTH-1:0] winner;

    logic [1:0]              count;
    logic                    buf_full;
    logic                    push;
    logic                    pop;
    logic [T_DATA_WIDTH-1:0] in_data;
    logic                    in_last;

    logic [T_DATA_WIDTH-1:0] skid_data;
    logic [T_QOS__WIDTH-1:0] skid_qos;
    logic [T_ID___WIDTH-1:0] skid_id;
    logic                    skid_last;

    assign any_valid = |s_valid_in;

    // Urgent streams override QoS entirely; otherwise only the top QoS level competes.
    always_comb begin
        // NOTE: every signal gets a default before the loop so no latch is inferred.
        max_qos = '0;
        urgent  = '0;
        cand    = '0;
        for (int i = 0; i < STREAM_COUNT; i++) begin
            if (s_valid_in[i] && s_qos_in[i] > max_qos) max_qos = s_qos_in[i];
            urgent[i] = s_valid_in[i] && (age[i] == AGE_WIDTH'(AGE_LIMIT));
        end
        for (int i = 0; i < STREAM_COUNT; i++) begin
            cand[i] = (|urgent) ? urgent[i] : (s_valid_in[i] && s_qos_in[i] == max_qos);
        end
    end

    always_comb begin : winner_sel
        logic found;
        int   idx;
        found  = 1'b0;
        idx    = 0;
        winner = rr_ptr;
        for (int i = 1; i <= STREAM_COUNT; i++) begin
            idx = (int'(rr_ptr) + i) % STREAM_COUNT;
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = T_ID___WIDTH'(idx);
            end
        end
    end

    assign buf_full    = (count == 2'd2);
    assign m_valid_out = (count != 2'd0);
    assign pop         = m_valid_out && m_ready_in;
    assign push        = (state == ST_XFER) && !buf_full && s_valid_in[grant];
    assign in_data     = s_data_in[grant];
    assign in_last     = s_last_in[grant];

    // Ready depends only on registered state, never on m_ready_in.
    always_comb begin
        s_ready_out = '0;
        if (state == ST_XFER && !buf_full) s_ready_out[grant] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_ARB;
            grant   <= '0;
            rr_ptr  <= T_ID___WIDTH'(STREAM_COUNT - 1);
            pkt_qos <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (any_valid) begin
                        grant   <= winner;
                        rr_ptr  <= winner;
                        pkt_qos <= s_qos_in[winner];
                        state   <= ST_XFER;
                    end
                end
                default: begin
                    if (push && in_last) state <= ST_ARB;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STREAM_COUNT; i++) age[i] <= '0;
        end else if (state == ST_ARB) begin
            for (int i = 0; i < STREAM_COUNT; i++) begin
                if (!s_valid_in[i] || winner == T_ID___WIDTH'(i)) begin
                    age[i] <= '0;
                end else if (age[i] != AGE_WIDTH'(AGE_LIMIT)) begin
                    age[i] <= age[i] + AGE_WIDTH'(1);
                end
            end
        end
    end

    // Head register drives m_* directly so fields hold their last value when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: buffer storage is reset too, so outputs read 0 before the first beat.
            count      <= 2'd0;
            m_data_out <= '0;
            m_qos_out  <= '0;
            m_id_out   <= '0;
            m_last_out <= 1'b0;
            skid_data  <= '0;
            skid_qos   <= '0;
            skid_id    <= '0;
            skid_last  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        m_data_out <= in_data;
                        m_qos_out  <= pkt_qos;
                        m_id_out   <= grant;
                        m_last_out <= in_last;
                    end else begin
                        skid_data  <= in_data;
                        skid_qos   <= pkt_qos;
                        skid_id    <= grant;
                        skid_last  <= in_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        m_data_out <= skid_data;
                        m_qos_out  <= skid_qos;
                        m_id_out   <= skid_id;
                        m_last_out <= skid_last;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry: the incoming beat replaces the head.
                    m_data_out <= in_data;
                    m_qos_out  <= pkt_qos;
                    m_id_out   <= grant;
                    m_last_out <= in_last;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_arbiter_qos_rr.sv
// Directed bench for stream_arbiter_qos_rr: per-stream packet scripts, a per-cycle
// sample log and an output beat log, checked inline by one task per scenario.
module tb_stream_arbiter_qos_rr;

    logic       clk;
    logic       rst;
    logic [7:0] s_data [4];
    logic [3:0] s_qos  [4];
    logic [3:0] s_last;
    logic [3:0] s_valid;
    logic [3:0] s_ready;
    logic [7:0] m_data;
    logic [3:0] m_qos;
    logic [1:0] m_id;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;

    int checks;
    int errors;

    logic [7:0] pk_data [4][16];
    logic       pk_last [4][16];
    logic [3:0] pk_qos  [4];
    int         pk_n    [4];
    int         pk_ptr  [4];
    bit         pk_en   [4];

    int         cyc;
    logic       cyc_valid [256];
    logic [3:0] cyc_ready [256];
    logic [7:0] cyc_data  [256];

    int         log_n;
    logic [7:0] log_d    [32];
    logic [3:0] log_q    [32];
    logic [1:0] log_id   [32];
    logic       log_last [32];

    stream_arbiter_qos_rr #(
        .T_DATA_WIDTH(8),
        .T_QOS__WIDTH(4),
        .STREAM_COUNT(4),
        .AGE_LIMIT   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data_in  (s_data),
        .s_qos_in   (s_qos),
        .s_last_in  (s_last),
        .s_valid_in (s_valid),
        .s_ready_out(s_ready),
        .m_data_out (m_data),
        .m_qos_out  (m_qos),
        .m_id_out   (m_id),
        .m_last_out (m_last),
        .m_valid_out(m_valid),
        .m_ready_in (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_inputs();
        for (int s = 0; s < 4; s++) begin
            s_qos[s] = pk_qos[s];
            if (pk_en[s] && pk_ptr[s] < pk_n[s]) begin
                s_valid[s] = 1'b1;
                s_data[s]  = pk_data[s][pk_ptr[s]];
                s_last[s]  = pk_last[s][pk_ptr[s]];
            end else begin
                s_valid[s] = 1'b0;
                s_data[s]  = 8'h00;
                s_last[s]  = 1'b0;
            end
        end
    endtask

    task automatic clear_streams();
        for (int s = 0; s < 4; s++) begin
            pk_n[s]   = 0;
            pk_ptr[s] = 0;
            pk_en[s]  = 1'b0;
            pk_qos[s] = 4'h0;
        end
        cyc   = 0;
        log_n = 0;
        drive_inputs();
    endtask

    task automatic add_beat(input int s, input logic [7:0] d, input logic l);
        pk_data[s][pk_n[s]] = d;
        pk_last[s][pk_n[s]] = l;
        pk_n[s]++;
    endtask

    // Leaves the bench at posedge+1 with rst released and the DUT idle in ARB.
    task automatic do_reset();
        rst     = 1'b1;
        m_ready = 1'b1;
        clear_streams();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step();
        logic [3:0] acc;
        @(negedge clk);
        acc = s_valid & s_ready;
        if (cyc < 256) begin
            cyc_valid[cyc] = m_valid;
            cyc_ready[cyc] = s_ready;
            cyc_data[cyc]  = m_data;
        end
        if (m_valid && m_ready && log_n < 32) begin
            log_d[log_n]    = m_data;
            log_q[log_n]    = m_qos;
            log_id[log_n]   = m_id;
            log_last[log_n] = m_last;
            log_n++;
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) if (acc[s]) pk_ptr[s]++;
        drive_inputs();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        m_ready = 1'b1;
        clear_streams();
        @(negedge clk);
        checks++;
        if ({m_valid, m_last, m_data, m_qos, m_id} !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h q=%h id=%h expected all zero",
                     m_valid, m_last, m_data, m_qos, m_id);
        end
        checks++;
        if (s_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0000", s_ready);
        end
        do_reset();
        repeat (3) step();
        checks++;
        if (cyc_valid[2] !== 1'b0 || cyc_ready[2] !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: got v=%b rdy=%b expected v=0 rdy=0000",
                     cyc_valid[2], cyc_ready[2]);
        end
    endtask

    task automatic test_qos_priority();
        logic [7:0] exp_d [4];
        logic [1:0] exp_id [4];
        logic [3:0] exp_q [4];
        logic       exp_l [4];
        exp_d  = '{8'hC1, 8'hC2, 8'hA1, 8'hA2};
        exp_id = '{2'd2, 2'd2, 2'd0, 2'd0};
        exp_q  = '{4'd3, 4'd3, 4'd1, 4'd1};
        exp_l  = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        pk_qos[0] = 4'd1; add_beat(0, 8'hA1, 1'b0); add_beat(0, 8'hA2, 1'b1); pk_en[0] = 1'b1;
        pk_qos[2] = 4'd3; add_beat(2, 8'hC1, 1'b0); add_beat(2, 8'hC2, 1'b1); pk_en[2] = 1'b1;
        drive_inputs();
        repeat (12) step();
        checks++;
        if (cyc_ready[0] !== 4'b0000 || cyc_ready[1] !== 4'b0100) begin
            errors++;
            $display("FAIL qos_ready_latency: got c0=%b c1=%b expected c0=0000 c1=0100",
                     cyc_ready[0], cyc_ready[1]);
        end
        checks++;
        if (cyc_valid[1] !== 1'b0 || cyc_valid[2] !== 1'b1) begin
            errors++;
            $display("FAIL qos_out_latency: got c1=%b c2=%b expected c1=0 c2=1",
                     cyc_valid[1], cyc_valid[2]);
        end
        checks++;
        if (log_n !== 4) begin
            errors++;
            $display("FAIL qos_beat_count: got %0d expected 4", log_n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_d[i] !== exp_d[i] || log_id[i] !== exp_id[i] ||
                log_q[i] !== exp_q[i] || log_last[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL qos_beat[%0d]: got d=%h id=%0d q=%0d l=%b expected d=%h id=%0d q=%0d l=%b",
                         i, log_d[i], log_id[i], log_q[i], log_last[i],
                         exp_d[i], exp_id[i], exp_q[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_rr_tie();
        logic [7:0] exp_d [6];
        logic [1:0] exp_id [6];
        exp_d  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        for (int s = 0; s < 4; s++) begin
            pk_qos[s] = 4'd2;
            pk_en[s]  = 1'b1;
            add_beat(s, 8'h10 + 8'(s), 1'b1);
        end
        add_beat(0, 8'h14, 1'b1);
        add_beat(1, 8'h15, 1'b1);
        drive_inputs();
        repeat (16) step();
        checks++;
        if (log_n !== 6) begin
            errors++;
            $display("FAIL rr_beat_count: got %0d expected 6", log_n);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (log_d[i] !== exp_d[i] || log_id[i] !== exp_id[i] || log_last[i] !== 1'b1) begin
                errors++;
                $display("FAIL rr_beat[%0d]: got d=%h id=%0d l=%b expected d=%h id=%0d l=1",
                         i, log_d[i], log_id[i], log_last[i], exp_d[i], exp_id[i]);
            end
        end
        for (int c = 2; c <= 12; c++) begin
            checks++;
            if (cyc_valid[c] !== ((c % 2) == 0)) begin
                errors++;
                $display("FAIL rr_valid_gap[c%0d]: got %b expected %b",
                         c, cyc_valid[c], ((c % 2) == 0));
            end
        end
    endtask

    task automatic test_lock();
        logic [7:0] exp_d [4];
        logic [1:0] exp_id [4];
        exp_d  = '{8'h31, 8'h32, 8'h33, 8'hF1};
        exp_id = '{2'd1, 2'd1, 2'd1, 2'd3};
        do_reset();
        pk_qos[1] = 4'd0;
        add_beat(1, 8'h31, 1'b0); add_beat(1, 8'h32, 1'b0); add_beat(1, 8'h33, 1'b1);
        pk_en[1] = 1'b1;
        pk_qos[3] = 4'd15;
        add_beat(3, 8'hF1, 1'b1);
        drive_inputs();
        step();
        step();
        // Beat 2 of s1 is on the bus now; the high-QoS stream arrives here.
        pk_en[3] = 1'b1;
        drive_inputs();
        repeat (7) step();
        for (int c = 0; c <= 4; c++) begin
            checks++;
            if (cyc_ready[c][3] !== 1'b0) begin
                errors++;
                $display("FAIL lock_ready3[c%0d]: got %b expected 0", c, cyc_ready[c][3]);
            end
        end
        checks++;
        if (cyc_ready[5] !== 4'b1000) begin
            errors++;
            $display("FAIL lock_ready_after: got %b expected 1000", cyc_ready[5]);
        end
        checks++;
        if (log_n !== 4) begin
            errors++;
            $display("FAIL lock_beat_count: got %0d expected 4", log_n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_d[i] !== exp_d[i] || log_id[i] !== exp_id[i]) begin
                errors++;
                $display("FAIL lock_beat[%0d]: got d=%h id=%0d expected d=%h id=%0d",
                         i, log_d[i], log_id[i], exp_d[i], exp_id[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        pk_qos[2] = 4'd5;
        add_beat(2, 8'h41, 1'b0); add_beat(2, 8'h42, 1'b0);
        add_beat(2, 8'h43, 1'b0); add_beat(2, 8'h44, 1'b1);
        pk_en[2] = 1'b1;
        drive_inputs();
        step();
        step();
        m_ready = 1'b0;
        repeat (5) step();
        checks++;
        if (pk_ptr[2] !== 2) begin
            errors++;
            $display("FAIL bp_buffered: got %0d beats accepted expected 2", pk_ptr[2]);
        end
        m_ready = 1'b1;
        repeat (6) step();
        checks++;
        if (cyc_ready[2] !== 4'b0100) begin
            errors++;
            $display("FAIL bp_ready_before_full: got %b expected 0100", cyc_ready[2]);
        end
        for (int c = 3; c <= 7; c++) begin
            checks++;
            if (cyc_ready[c] !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready_full[c%0d]: got %b expected 0000", c, cyc_ready[c]);
            end
        end
        for (int c = 2; c <= 6; c++) begin
            checks++;
            if (cyc_valid[c] !== 1'b1 || cyc_data[c] !== 8'h41) begin
                errors++;
                $display("FAIL bp_stable[c%0d]: got v=%b d=%h expected v=1 d=41",
                         c, cyc_valid[c], cyc_data[c]);
            end
        end
        checks++;
        if (log_n !== 4) begin
            errors++;
            $display("FAIL bp_beat_count: got %0d expected 4", log_n);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_d[i] !== 8'h41 + 8'(i) || log_id[i] !== 2'd2 || log_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL bp_beat[%0d]: got d=%h id=%0d l=%b expected d=%h id=2 l=%b",
                         i, log_d[i], log_id[i], log_last[i], 8'h41 + 8'(i), (i == 3));
            end
        end
    endtask

    task automatic test_aging();
        logic [7:0] exp_d [10];
        logic [1:0] exp_id [10];
        exp_d  = '{8'hD0, 8'hD1, 8'hD2, 8'hE0, 8'hD3, 8'hD4, 8'hD5, 8'hE1, 8'hD6, 8'hD7};
        exp_id = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3};
        do_reset();
        pk_qos[3] = 4'd15;
        for (int i = 0; i < 8; i++) add_beat(3, 8'hD0 + 8'(i), 1'b1);
        pk_qos[0] = 4'd0;
        add_beat(0, 8'hE0, 1'b1);
        add_beat(0, 8'hE1, 1'b1);
        pk_en[0] = 1'b1;
        pk_en[3] = 1'b1;
        drive_inputs();
        repeat (26) step();
        checks++;
        if (log_n !== 10) begin
            errors++;
            $display("FAIL age_beat_count: got %0d expected 10", log_n);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (log_d[i] !== exp_d[i] || log_id[i] !== exp_id[i]) begin
                errors++;
                $display("FAIL age_beat[%0d]: got d=%h id=%0d expected d=%h id=%0d",
                         i, log_d[i], log_id[i], exp_d[i], exp_id[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        pk_qos[0] = 4'd2;
        add_beat(0, 8'h61, 1'b0); add_beat(0, 8'h62, 1'b0); add_beat(0, 8'h63, 1'b1);
        pk_en[0] = 1'b1;
        drive_inputs();
        step();
        step();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h61) begin
            errors++;
            $display("FAIL rmp_before: got v=%b d=%h expected v=1 d=61", m_valid, m_data);
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({m_valid, m_last, m_data, m_qos, m_id} !== 19'h0 || s_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rmp_async: got v=%b l=%b d=%h q=%h id=%h rdy=%b expected all zero",
                     m_valid, m_last, m_data, m_qos, m_id, s_ready);
        end
        clear_streams();
        @(posedge clk);
        #1 rst = 1'b0;
        pk_qos[0] = 4'd2; add_beat(0, 8'h70, 1'b1); pk_en[0] = 1'b1;
        pk_qos[1] = 4'd2; add_beat(1, 8'h71, 1'b1); pk_en[1] = 1'b1;
        drive_inputs();
        repeat (8) step();
        checks++;
        if (log_n !== 2) begin
            errors++;
            $display("FAIL rmp_beat_count: got %0d expected 2", log_n);
        end
        checks++;
        if (log_d[0] !== 8'h70 || log_id[0] !== 2'd0 || log_d[1] !== 8'h71 || log_id[1] !== 2'd1) begin
            errors++;
            $display("FAIL rmp_tie: got %h/%0d,%h/%0d expected 70/0,71/1",
                     log_d[0], log_id[0], log_d[1], log_id[1]);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        m_ready = 1'b1;
        test_reset();
        test_qos_priority();
        test_rr_tie();
        test_lock();
        test_backpressure();
        test_aging();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
